// File: rtl/reg_wb_stage_if.sv
// Writeback stage bus: retiring-instruction handshake, load response, flush and
// register-file write port.
interface reg_wb_stage_if #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [6:0]                in_opcode;
  logic [2:0]                in_funct3;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic [WORD_WIDTH-1:0]     in_imm;
  logic [WORD_WIDTH-1:0]     in_inst_addr;
  logic [WORD_WIDTH-1:0]     in_alu_result;
  logic                      in_alu_result_valid;
  logic                      mem_resp_valid;
  logic [WORD_WIDTH-1:0]     mem_resp_data;
  logic                      flush;
  logic                      reg_wren;
  logic [REG_ADDR_WIDTH-1:0] reg_waddr;
  logic [WORD_WIDTH-1:0]     reg_data_in;
  logic                      busy;
  logic                      wb_err;

  modport master (
    output in_valid, in_opcode, in_funct3, in_rd, in_imm, in_inst_addr,
           in_alu_result, in_alu_result_valid, mem_resp_valid, mem_resp_data, flush,
    input  in_ready, reg_wren, reg_waddr, reg_data_in, busy, wb_err
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_rd, in_imm, in_inst_addr,
           in_alu_result, in_alu_result_valid, mem_resp_valid, mem_resp_data, flush,
    output in_ready, reg_wren, reg_waddr, reg_data_in, busy, wb_err
  );
endinterface

// File: rtl/reg_wb_stage.sv
// Registered register-file writeback stage: selects ALU/LUI/link/load data,
// waits for load responses with timeout, and issues a one-cycle register write.
module reg_wb_stage #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT    = 16
) (
  input  logic           clk,
  input  logic           rst,
  reg_wb_stage_if.slave  bus
);
  localparam int unsigned OFS   = $clog2(WORD_WIDTH / 8);
  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [REG_ADDR_WIDTH-1:0] ld_rd_q, waddr_d;
  logic [2:0]                ld_f3_q;
  logic [OFS-1:0]            ld_ofs_q, in_ofs;
  logic [WORD_WIDTH-1:0]     data_d, lane, ld_data;
  logic                      accept, ld_start, ld_legal, ld_misalign, err_d;

  assign bus.in_ready = (state_q != WAIT_MEM) & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;
  assign in_ofs       = bus.in_alu_result[OFS-1:0];

  // Byte-lane extraction and extension of the pending load
  always_comb begin
    lane = bus.mem_resp_data >> {ld_ofs_q, 3'b000};
    case (ld_f3_q)
      F3_LB:   ld_data = WORD_WIDTH'($signed(lane[7:0]));
      F3_LH:   ld_data = WORD_WIDTH'($signed(lane[15:0]));
      F3_LW:   ld_data = WORD_WIDTH'($signed(lane[31:0]));
      F3_LHU:  ld_data = WORD_WIDTH'(lane[15:0]);
      default: ld_data = WORD_WIDTH'(lane[7:0]);
    endcase
  end

  // Load width legality and alignment of the offered instruction
  always_comb begin
    ld_legal    = 1'b1;
    ld_misalign = 1'b0;
    case (bus.in_funct3)
      F3_LB, F3_LBU: ld_misalign = 1'b0;
      F3_LH, F3_LHU: ld_misalign = in_ofs[0];
      F3_LW:         ld_misalign = (in_ofs[1:0] != 2'b00);
      default:       ld_legal    = 1'b0;
    endcase
  end

  // Next state, write payload and error selection
  always_comb begin
    state_d  = IDLE;
    cnt_d    = cnt_q;
    waddr_d  = bus.reg_waddr;
    data_d   = bus.reg_data_in;
    err_d    = 1'b0;
    ld_start = 1'b0;
    if (!bus.flush) begin
      if (state_q == WAIT_MEM) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.mem_resp_valid) begin
          if (ld_rd_q != '0) begin
            state_d = WRITE;
            waddr_d = ld_rd_q;
            data_d  = ld_data;
          end
        end else if (cnt_d == CNT_W'(MEM_TIMEOUT)) begin
          err_d = 1'b1;
        end else begin
          state_d = WAIT_MEM;
        end
      end else if (accept) begin
        if (bus.in_opcode == OP_LOAD) begin
          if (!ld_legal || ld_misalign) begin
            err_d = 1'b1;
          end else begin
            ld_start = 1'b1;
            cnt_d    = '0;
            state_d  = WAIT_MEM;
          end
        end else if (bus.in_opcode == OP_STORE || bus.in_opcode == OP_BRANCH ||
                     bus.in_rd == '0) begin
          state_d = IDLE;
        end else if (bus.in_opcode == OP_LUI) begin
          state_d = WRITE;
          waddr_d = bus.in_rd;
          data_d  = bus.in_imm;
        end else if (bus.in_opcode == OP_JAL || bus.in_opcode == OP_JALR) begin
          state_d = WRITE;
          waddr_d = bus.in_rd;
          data_d  = bus.in_inst_addr + WORD_WIDTH'(4);
        end else if (!bus.in_alu_result_valid) begin
          err_d = 1'b1;
        end else begin
          state_d = WRITE;
          waddr_d = bus.in_rd;
          data_d  = bus.in_alu_result;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      ld_rd_q         <= '0;
      ld_f3_q         <= '0;
      ld_ofs_q        <= '0;
      bus.reg_wren    <= 1'b0;
      bus.reg_waddr   <= '0;
      bus.reg_data_in <= '0;
      bus.busy        <= 1'b0;
      bus.wb_err      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bus.reg_wren    <= (state_d == WRITE);
      bus.reg_waddr   <= waddr_d;
      bus.reg_data_in <= data_d;
      bus.busy        <= (state_d == WAIT_MEM);
      bus.wb_err      <= err_d;
      if (ld_start) begin
        ld_rd_q  <= bus.in_rd;
        ld_f3_q  <= bus.in_funct3;
        ld_ofs_q <= in_ofs;
      end
    end
  end
endmodule

// File: tb/tb_reg_wb_stage.sv
// Directed self-checking bench for reg_wb_stage.
module tb_reg_wb_stage;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  reg_wb_stage_if #(.WORD_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  reg_wb_stage #(.WORD_WIDTH(32), .REG_ADDR_WIDTH(5), .MEM_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic av, input logic [31:0] pc,
                       input logic [31:0] imm);
    bus.in_valid            = 1'b1;
    bus.in_opcode           = op;
    bus.in_funct3           = f3;
    bus.in_rd               = rd;
    bus.in_alu_result       = alu;
    bus.in_alu_result_valid = av;
    bus.in_inst_addr        = pc;
    bus.in_imm              = imm;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Accept a load, wait, return data, and expect a write one cycle after the response
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] data, input int waits,
                         input logic [31:0] exp);
    issue(OP_LOAD, f3, rd, addr, 1'b1, 32'h0, 32'h0);
    tick();
    idle();
    chk({tag, " busy"}, bus.busy, 1);
    chk({tag, " ready_low"}, bus.in_ready, 0);
    repeat (waits) tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = data;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk({tag, " wren"}, bus.reg_wren, 1);
    chk({tag, " waddr"}, bus.reg_waddr, 32'(rd));
    chk({tag, " data"}, bus.reg_data_in, exp);
    chk({tag, " busy_clr"}, bus.busy, 0);
    tick();
    chk({tag, " wren_off"}, bus.reg_wren, 0);
  endtask

  // Non-load whose accept must produce no write and the given error flag
  task automatic no_write(input string tag, input logic [6:0] op, input logic [4:0] rd,
                          input logic av, input logic err);
    issue(op, 3'b000, rd, 32'h55, av, 32'h100, 32'h7000);
    tick();
    idle();
    chk({tag, " wren"}, bus.reg_wren, 0);
    chk({tag, " err"}, bus.wb_err, 32'(err));
    tick();
    chk({tag, " err_off"}, bus.wb_err, 0);
  endtask

  task automatic bad_load(input string tag, input logic [2:0] f3, input logic [31:0] addr);
    issue(OP_LOAD, f3, 5'd4, addr, 1'b1, 32'h0, 32'h0);
    tick();
    idle();
    chk({tag, " err"}, bus.wb_err, 1);
    chk({tag, " wren"}, bus.reg_wren, 0);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " ready"}, bus.in_ready, 1);
    tick();
    chk({tag, " err_off"}, bus.wb_err, 0);
  endtask

  initial begin
    int n;
    bus.in_valid = 0; bus.in_opcode = 0; bus.in_funct3 = 0; bus.in_rd = 0;
    bus.in_imm = 0; bus.in_inst_addr = 0; bus.in_alu_result = 0;
    bus.in_alu_result_valid = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = 0;
    bus.flush = 0;

    tick();
    tick();
    chk("rst wren", bus.reg_wren, 0);
    chk("rst waddr", bus.reg_waddr, 0);
    chk("rst data", bus.reg_data_in, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst err", bus.wb_err, 0);
    rst = 1'b0;
    #1;
    chk("idle ready", bus.in_ready, 1);

    // Back-to-back ALU writes
    issue(OP_ALU, 3'b000, 5'd5, 32'h1234, 1'b1, 32'h0, 32'h0);
    tick();
    chk("alu1 wren", bus.reg_wren, 1);
    chk("alu1 waddr", bus.reg_waddr, 5);
    chk("alu1 data", bus.reg_data_in, 32'h0000_1234);
    chk("alu1 ready_in_write", bus.in_ready, 1);
    issue(OP_ALU, 3'b000, 5'd6, 32'h5678, 1'b1, 32'h0, 32'h0);
    tick();
    idle();
    chk("alu2 wren", bus.reg_wren, 1);
    chk("alu2 waddr", bus.reg_waddr, 6);
    chk("alu2 data", bus.reg_data_in, 32'h0000_5678);
    tick();
    chk("alu2 wren_off", bus.reg_wren, 0);
    chk("alu2 data_hold", bus.reg_data_in, 32'h0000_5678);

    // Loads with lane extraction and extension
    do_load("lb", 3'b000, 5'd7, 32'h1003, 32'h80FF_0000, 2, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 5'd8, 32'h1003, 32'h80FF_0000, 2, 32'h0000_0080);
    do_load("lh", 3'b001, 5'd9, 32'h1002, 32'h80FF_0000, 0, 32'hFFFF_80FF);
    do_load("lhu", 3'b101, 5'd10, 32'h1002, 32'h80FF_0000, 1, 32'h0000_80FF);
    do_load("lw", 3'b010, 5'd11, 32'h1000, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);
    do_load("lb_ofs1", 3'b000, 5'd12, 32'h1001, 32'h1234_5678, 0, 32'h0000_0056);

    // Misaligned and illegal loads
    bad_load("lh_mis", 3'b001, 32'h1003);
    bad_load("lw_mis", 3'b010, 32'h1002);
    bad_load("f3_bad", 3'b011, 32'h1000);

    // Link address wrap, JALR, LUI
    issue(OP_JAL, 3'b000, 5'd1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    tick();
    chk("jal wren", bus.reg_wren, 1);
    chk("jal waddr", bus.reg_waddr, 1);
    chk("jal wrap", bus.reg_data_in, 32'h0000_0000);
    issue(OP_JALR, 3'b000, 5'd2, 32'h0, 1'b0, 32'h0000_0100, 32'h0);
    tick();
    chk("jalr data", bus.reg_data_in, 32'h0000_0104);
    issue(OP_LUI, 3'b000, 5'd3, 32'h0, 1'b0, 32'h0, 32'hABCD_E000);
    tick();
    idle();
    chk("lui waddr", bus.reg_waddr, 3);
    chk("lui data", bus.reg_data_in, 32'hABCD_E000);
    tick();

    no_write("jal_x0", OP_JAL, 5'd0, 1'b1, 1'b0);
    no_write("store", OP_STORE, 5'd5, 1'b1, 1'b0);
    no_write("branch", OP_BRANCH, 5'd5, 1'b1, 1'b0);
    no_write("alu_invalid", OP_ALU, 5'd9, 1'b0, 1'b1);
    chk("data_hold_after_nowrite", bus.reg_data_in, 32'hABCD_E000);

    // Load timeout, then a late response is ignored
    issue(OP_LOAD, 3'b010, 5'd13, 32'h2000, 1'b1, 32'h0, 32'h0);
    tick();
    idle();
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      tick();
    end
    chk("timeout cycles", 32'(n), 16);
    chk("timeout err", bus.wb_err, 1);
    chk("timeout wren", bus.reg_wren, 0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h1111_1111;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("late resp wren", bus.reg_wren, 0);
    chk("late resp busy", bus.busy, 0);
    chk("late resp err", bus.wb_err, 0);

    // Response arriving in the final wait cycle wins over the timeout
    issue(OP_LOAD, 3'b010, 5'd14, 32'h2000, 1'b1, 32'h0, 32'h0);
    tick();
    idle();
    repeat (15) tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'hCAFE_F00D;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("edge resp wren", bus.reg_wren, 1);
    chk("edge resp err", bus.wb_err, 0);
    chk("edge resp data", bus.reg_data_in, 32'hCAFE_F00D);
    tick();

    // Load with rd=x0 waits but never writes
    issue(OP_LOAD, 3'b000, 5'd0, 32'h1000, 1'b1, 32'h0, 32'h0);
    tick();
    idle();
    chk("ld_x0 busy", bus.busy, 1);
    bus.mem_resp_valid = 1'b1;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("ld_x0 wren", bus.reg_wren, 0);
    chk("ld_x0 busy_clr", bus.busy, 0);

    // Flush during WAIT_MEM drops the load silently
    issue(OP_LOAD, 3'b000, 5'd15, 32'h1000, 1'b1, 32'h0, 32'h0);
    tick();
    idle();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush busy", bus.busy, 0);
    chk("flush err", bus.wb_err, 0);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0000_00AA;
    tick();
    bus.mem_resp_valid = 1'b0;
    chk("flush resp wren", bus.reg_wren, 0);
    chk("flush resp err", bus.wb_err, 0);

    // Flush with in_valid blocks the accept
    issue(OP_ALU, 3'b000, 5'd11, 32'h9999, 1'b1, 32'h0, 32'h0);
    bus.flush = 1'b1;
    #1;
    chk("flush ready", bus.in_ready, 0);
    tick();
    idle();
    bus.flush = 1'b0;
    chk("flush inst wren", bus.reg_wren, 0);
    tick();
    chk("flush inst not consumed", bus.reg_wren, 0);

    // Reset during WRITE cancels the write
    issue(OP_ALU, 3'b000, 5'd12, 32'h4242, 1'b1, 32'h0, 32'h0);
    tick();
    idle();
    chk("pre-rst wren", bus.reg_wren, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst-in-write wren", bus.reg_wren, 0);
    chk("rst-in-write data", bus.reg_data_in, 0);
    tick();
    chk("post-rst wren", bus.reg_wren, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_wb_stage.md
Name: reg_wb_stage

Overview:
- Registered register-file writeback stage for the RISC-V core, replacing purely combinational writeback selection.
- Accepts one retiring instruction per handshake and selects the result: ALU result, LUI immediate, link address, or memory load data.
- Waits a variable number of cycles for the load response, then extracts the byte lane, sign- or zero-extends it, and issues a one-cycle register write.
- Adds rd==x0 suppression, misalignment and timeout error reporting, and a flush.

Parameters:
- WORD_WIDTH, 32, datapath width. Must be a multiple of 8 and at least 32. OFS = log2(WORD_WIDTH/8) address-offset bits.
- REG_ADDR_WIDTH, 5, register index width.
- MEM_TIMEOUT, 16, maximum cycles spent in WAIT_MEM before abort. Must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept.
- in_opcode  in  7  opcode.
- in_funct3  in  3  load width code.
- in_rd  in  REG_ADDR_WIDTH  destination register.
- in_imm  in  WORD_WIDTH  U-immediate, already shifted.
- in_inst_addr  in  WORD_WIDTH  instruction PC.
- in_alu_result  in  WORD_WIDTH  ALU result; this is the effective address for loads.
- in_alu_result_valid  in  1  ALU result usable.
- mem_resp_valid  in  1  load data present.
- mem_resp_data  in  WORD_WIDTH  aligned memory word.
- flush  in  1  kill in-flight work.
- reg_wren  out  1  register-file write enable.
- reg_waddr  out  REG_ADDR_WIDTH  write index.
- reg_data_in  out  WORD_WIDTH  write data.
- busy  out  1  a load is pending (high in WAIT_MEM).
- wb_err  out  1  one-cycle error pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - reg_wren, reg_waddr, reg_data_in, busy and wb_err are all 0.
  - The timeout counter is 0.
- Opcodes: LUI 0110111, JAL 1101111, JALR 1100111, LOAD 0000011, STORE 0100011, BRANCH 1100011. Any other opcode is ALU-sourced.
- States: IDLE, WAIT_MEM, WRITE. All outputs are registered.
- in_ready = (state != WAIT_MEM) & ~flush. An accept occurs when in_valid & in_ready.
- On accept of a non-load:
  - BRANCH, STORE, or rd==0: consumed, no write, next state IDLE.
  - Otherwise data is selected as follows and the next state is WRITE:
    - LUI: in_imm.
    - JAL or JALR: in_inst_addr+4, modulo 2^WORD_WIDTH.
    - Any other opcode: in_alu_result.
  - ALU-sourced with in_alu_result_valid=0: no write, wb_err pulses the next cycle, next state IDLE.
- On accept of a LOAD:
  - Capture rd, funct3 and ofs = in_alu_result[OFS-1:0].
  - Legal funct3 codes: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Illegal funct3 gives wb_err, no memory wait, next state IDLE.
  - Misaligned access gives wb_err and next state IDLE: half with ofs[0]=1, or word with ofs[1:0]!=0.
  - Otherwise next state is WAIT_MEM and the counter is cleared.
  - A load with rd==0 still waits for its response, then performs no write.
- WAIT_MEM:
  - busy=1 and the counter increments each cycle.
  - On mem_resp_valid, extract the lane at byte offset ofs: byte [8*ofs+7:8*ofs]; half [8*ofs+15:8*ofs]; word [8*ofs+31:8*ofs].
  - Sign-extend for LB, LH and LW (LW extends only when WORD_WIDTH>32). Zero-extend for LBU and LHU.
  - Next state is WRITE.
  - If the counter reaches MEM_TIMEOUT with no response: wb_err, next state IDLE.
  - A response in the same cycle as the timeout wins.
- WRITE:
  - reg_wren=1 for exactly one cycle, with reg_waddr and reg_data_in valid.
  - The stage may accept a new instruction in the same cycle (back-to-back throughput of 1 per cycle for non-loads).
- Latency:
  - Non-load: accept in cycle N gives reg_wren in cycle N+1.
  - Load: response in cycle M gives reg_wren in cycle M+1.
- reg_wren=0 outside WRITE. reg_data_in holds its last value when idle.
- flush:
  - Next state is IDLE, the pending load is dropped, and a WRITE in progress is cancelled (reg_wren=0 the next cycle).
  - No wb_err is raised by a flush.
  - flush wins over a simultaneous in_valid or mem_resp_valid.
  - mem_resp_valid while in IDLE or WRITE is ignored.
- rst during WAIT_MEM or WRITE behaves as reset. No write is issued.

Test Plan:
- ALU op, rd=5, alu_result=0x1234, result_valid=1 -> next cycle reg_wren=1, waddr=5, data=0x00001234. Back-to-back second op rd=6 -> wren again the following cycle.
- LB: addr=0x1003, response after 3 cycles with data 0x80FF_0000 -> byte at ofs 3 = 0x80 -> data 0xFFFFFF80, one cycle after the response. Same sequence with LBU -> 0x00000080.
- LH with addr ofs=3 -> wb_err pulse, no wren, in_ready high next cycle. LW with ofs=2 -> same.
- JAL with pc=0xFFFFFFFC, rd=1 -> data 0x00000000 (wrap). JAL with rd=0 -> no wren. STORE and BRANCH -> no wren.
- Load pending, no response for MEM_TIMEOUT=16 cycles -> wb_err and return to IDLE. A late mem_resp_valid after that is ignored.
- Flush during WAIT_MEM, then mem_resp_valid the next cycle -> no wren, no err. flush together with in_valid -> in_ready=0 and the instruction is not consumed. rst asserted in WRITE -> reg_wren=0 the next cycle.
